// File: rtl/lane_box_if.sv
// Painter request/pixel bundle: the controller drives start/mask/colour and the painter returns
// one VGA pixel write per cycle plus busy/done status.
interface lane_box_if #(
   parameter int PLAYERS = 2
);
   logic               start;
   logic [PLAYERS-1:0] player_mask;
   logic [2:0]         colour_in;
   logic [7:0]         x;
   logic [6:0]         y;
   logic [2:0]         colour;
   logic               plot;
   logic               busy;
   logic               done;

   modport master (
      output start, player_mask, colour_in,
      input  x, y, colour, plot, busy, done
   );

   modport slave (
      input  start, player_mask, colour_in,
      output x, y, colour, plot, busy, done
   );
endinterface

// File: rtl/lane_box_painter.sv
// Repaints every enabled player's lane boxes, one pixel per cycle; first pixel is registered on the
// edge that accepts start. There is no backpressure: start is ignored while a repaint is in flight.
module lane_box_painter #(
   parameter int PLAYERS  = 2,
   parameter int X_BASE   = 38,
   parameter int X_STRIDE = 80,
   parameter int RIGHT_DX = 5,
   parameter int BOX_W    = 3,
   parameter int BOX_H    = 3
) (
   input  logic     clk,
   input  logic     reset,
   lane_box_if.slave bus
);

   typedef enum logic [1:0] {IDLE, PAINT, DONE} state_t;

   localparam logic [2:0] COL_LAST   = 3'(BOX_W - 1);
   localparam logic [2:0] ROW_LAST   = 3'(BOX_H - 1);
   localparam logic [4:0] LEFT_LAST  = 5'd16;
   localparam logic [4:0] RIGHT_LAST = 5'd15;

   state_t             state_q;
   logic [PLAYERS-1:0] mask_q;
   logic [2:0]         colour_q;
   logic [1:0]         ply_q;
   logic               side_q;
   logic [4:0]         idx_q;
   logic [2:0]         row_q;
   logic [2:0]         col_q;
   logic [7:0]         x_q;
   logic [6:0]         y_q;
   logic               plot_q;
   logic               busy_q;
   logic               done_q;

   logic [1:0]         ply_d;
   logic               side_d;
   logic [4:0]         idx_d;
   logic [2:0]         row_d;
   logic [2:0]         col_d;
   logic               last_pix;
   logic [1:0]         first_ply;
   logic [1:0]         nxt_ply;
   logic               nxt_found;

   function automatic logic [6:0] left_y(input logic [4:0] i);
      case (i)
         5'd0:  left_y = 7'd4;
         5'd1:  left_y = 7'd13;
         5'd2:  left_y = 7'd19;
         5'd3:  left_y = 7'd22;
         5'd4:  left_y = 7'd25;
         5'd5:  left_y = 7'd31;
         5'd6:  left_y = 7'd37;
         5'd7:  left_y = 7'd49;
         5'd8:  left_y = 7'd58;
         5'd9:  left_y = 7'd61;
         5'd10: left_y = 7'd67;
         5'd11: left_y = 7'd76;
         5'd12: left_y = 7'd82;
         5'd13: left_y = 7'd85;
         5'd14: left_y = 7'd88;
         5'd15: left_y = 7'd94;
         5'd16: left_y = 7'd97;
         default: left_y = 7'd0;
      endcase
   endfunction

   function automatic logic [6:0] right_y(input logic [4:0] i);
      case (i)
         5'd0:  right_y = 7'd7;
         5'd1:  right_y = 7'd10;
         5'd2:  right_y = 7'd16;
         5'd3:  right_y = 7'd28;
         5'd4:  right_y = 7'd34;
         5'd5:  right_y = 7'd40;
         5'd6:  right_y = 7'd43;
         5'd7:  right_y = 7'd46;
         5'd8:  right_y = 7'd52;
         5'd9:  right_y = 7'd55;
         5'd10: right_y = 7'd64;
         5'd11: right_y = 7'd70;
         5'd12: right_y = 7'd73;
         5'd13: right_y = 7'd79;
         5'd14: right_y = 7'd91;
         5'd15: right_y = 7'd100;
         default: right_y = 7'd0;
      endcase
   endfunction

   // Coordinates wrap silently; boxes near the frame edge are not clipped.
   function automatic logic [7:0] pix_x(input logic [1:0] p, input logic s, input logic [2:0] c);
      int v;
      v = X_BASE + int'(p) * X_STRIDE + (s ? RIGHT_DX : 0) + int'(c);
      return v[7:0];
   endfunction

   function automatic logic [6:0] pix_y(input logic s, input logic [4:0] i, input logic [2:0] r);
      logic [6:0] b;
      b = s ? right_y(i) : left_y(i);
      return b + {4'd0, r};
   endfunction

   always_comb begin
      first_ply = '0;
      for (int p = PLAYERS - 1; p >= 0; p--) begin
         if (bus.player_mask[p]) first_ply = 2'(p);
      end
      nxt_ply   = '0;
      nxt_found = 1'b0;
      for (int p = PLAYERS - 1; p >= 0; p--) begin
         if (mask_q[p] && (p > int'(ply_q))) begin
            nxt_ply   = 2'(p);
            nxt_found = 1'b1;
         end
      end

      ply_d    = ply_q;
      side_d   = side_q;
      idx_d    = idx_q;
      row_d    = row_q;
      col_d    = col_q;
      last_pix = 1'b0;
      // Odometer: column, row, table index, side, then next enabled player.
      if (col_q != COL_LAST) begin
         col_d = col_q + 3'd1;
      end else begin
         col_d = '0;
         if (row_q != ROW_LAST) begin
            row_d = row_q + 3'd1;
         end else begin
            row_d = '0;
            if (idx_q != (side_q ? RIGHT_LAST : LEFT_LAST)) begin
               idx_d = idx_q + 5'd1;
            end else begin
               idx_d = '0;
               if (!side_q) begin
                  side_d = 1'b1;
               end else begin
                  side_d   = 1'b0;
                  ply_d    = nxt_ply;
                  last_pix = !nxt_found;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         mask_q   <= '0;
         colour_q <= '0;
         ply_q    <= '0;
         side_q   <= 1'b0;
         idx_q    <= '0;
         row_q    <= '0;
         col_q    <= '0;
         x_q      <= '0;
         y_q      <= '0;
         plot_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               plot_q <= 1'b0;
               busy_q <= 1'b0;
               done_q <= 1'b0;
               if (bus.start) begin
                  mask_q   <= bus.player_mask;
                  colour_q <= bus.colour_in;
                  ply_q    <= first_ply;
                  side_q   <= 1'b0;
                  idx_q    <= '0;
                  row_q    <= '0;
                  col_q    <= '0;
                  if (|bus.player_mask) begin
                     state_q <= PAINT;
                     plot_q  <= 1'b1;
                     busy_q  <= 1'b1;
                     x_q     <= pix_x(first_ply, 1'b0, 3'd0);
                     y_q     <= pix_y(1'b0, 5'd0, 3'd0);
                  end else begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            PAINT: begin
               if (last_pix) begin
                  state_q <= DONE;
                  plot_q  <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  ply_q  <= ply_d;
                  side_q <= side_d;
                  idx_q  <= idx_d;
                  row_q  <= row_d;
                  col_q  <= col_d;
                  x_q    <= pix_x(ply_d, side_d, col_d);
                  y_q    <= pix_y(side_d, idx_d, row_d);
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.x      = x_q;
   assign bus.y      = y_q;
   assign bus.colour = colour_q;
   assign bus.plot   = plot_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;

endmodule

// File: tb/tb_lane_box_painter.sv
// Directed bench for lane_box_painter: default two-player instance plus a three-player 1x1-box instance.
module tb_lane_box_painter;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   lane_box_if #(.PLAYERS(2)) bus2 ();
   lane_box_if #(.PLAYERS(3)) bus3 ();

   lane_box_painter #(.PLAYERS(2)) dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2.slave)
   );

   lane_box_painter #(.PLAYERS(3), .BOX_W(1), .BOX_H(1)) dut3 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus3.slave)
   );

   int total = 0;
   int bad   = 0;

   logic [7:0] xs [0:1023];
   logic [6:0] ys [0:1023];
   logic [2:0] cs [0:1023];
   int         npix;
   int         busy_bad;

   task automatic kick2(input logic [1:0] mask, input logic [2:0] col);
      bus2.player_mask = mask;
      bus2.colour_in   = col;
      bus2.start       = 1'b1;
      @(posedge clk); #1;
      bus2.start       = 1'b0;
   endtask

   // Records pixels while plot is high; optionally pulses a conflicting start at one pixel.
   task automatic collect2(input int pulse_at);
      npix     = 0;
      busy_bad = 0;
      while (bus2.plot === 1'b1 && npix < 1024) begin
         xs[npix] = bus2.x;
         ys[npix] = bus2.y;
         cs[npix] = bus2.colour;
         if (bus2.busy !== 1'b1 || bus2.done !== 1'b0) busy_bad++;
         if (npix == pulse_at) begin
            bus2.start       = 1'b1;
            bus2.player_mask = 2'b01;
            bus2.colour_in   = 3'b101;
         end
         @(posedge clk); #1;
         if (npix == pulse_at) bus2.start = 1'b0;
         npix++;
      end
      if (bus2.busy !== 1'b0) busy_bad++;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({bus2.x, bus2.y, bus2.colour, bus2.plot, bus2.busy, bus2.done} !== 21'd0) begin
         bad++;
         $display("FAIL reset_outputs2: got %h expected 0",
                  {bus2.x, bus2.y, bus2.colour, bus2.plot, bus2.busy, bus2.done});
      end
      total++;
      if ({bus3.x, bus3.y, bus3.colour, bus3.plot, bus3.busy, bus3.done} !== 21'd0) begin
         bad++;
         $display("FAIL reset_outputs3: got %h expected 0",
                  {bus3.x, bus3.y, bus3.colour, bus3.plot, bus3.busy, bus3.done});
      end
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (bus2.plot !== 1'b0 || bus2.done !== 1'b0) begin
         bad++;
         $display("FAIL idle_after_reset: got plot=%b done=%b expected 0 0", bus2.plot, bus2.done);
      end
   endtask

   task automatic test_full_run();
      int col_bad;
      kick2(2'b11, 3'b111);
      collect2(-1);
      total++;
      if (bus2.done !== 1'b1) begin
         bad++;
         $display("FAIL full_done: got %b expected 1", bus2.done);
      end
      total++;
      if (npix !== 594) begin
         bad++;
         $display("FAIL full_count: got %0d expected 594", npix);
      end
      total++;
      if (xs[0] !== 8'd38 || ys[0] !== 7'd4) begin
         bad++;
         $display("FAIL full_first: got x=%0d y=%0d expected x=38 y=4", xs[0], ys[0]);
      end
      total++;
      if (xs[296] !== 8'd45 || ys[296] !== 7'd102) begin
         bad++;
         $display("FAIL full_p0_last: got x=%0d y=%0d expected x=45 y=102", xs[296], ys[296]);
      end
      total++;
      if (xs[297] !== 8'd118 || ys[297] !== 7'd4) begin
         bad++;
         $display("FAIL full_p1_first: got x=%0d y=%0d expected x=118 y=4", xs[297], ys[297]);
      end
      total++;
      if (xs[593] !== 8'd125 || ys[593] !== 7'd102) begin
         bad++;
         $display("FAIL full_last: got x=%0d y=%0d expected x=125 y=102", xs[593], ys[593]);
      end
      // Second pixel of the first box steps the column, fourth steps the row.
      total++;
      if (xs[1] !== 8'd39 || ys[1] !== 7'd4 || xs[3] !== 8'd38 || ys[3] !== 7'd5) begin
         bad++;
         $display("FAIL full_scan_order: got x1=%0d y1=%0d x3=%0d y3=%0d expected 39 4 38 5",
                  xs[1], ys[1], xs[3], ys[3]);
      end
      total++;
      if (busy_bad !== 0) begin
         bad++;
         $display("FAIL full_busy_track: got %0d bad cycles expected 0", busy_bad);
      end
      col_bad = 0;
      for (int i = 0; i < 594; i++) if (cs[i] !== 3'b111) col_bad++;
      total++;
      if (col_bad !== 0) begin
         bad++;
         $display("FAIL full_colour: got %0d wrong pixels expected 0", col_bad);
      end
      @(posedge clk); #1;
      total++;
      if (bus2.done !== 1'b0 || bus2.plot !== 1'b0) begin
         bad++;
         $display("FAIL full_done_pulse: got done=%b plot=%b expected 0 0", bus2.done, bus2.plot);
      end
   endtask

   task automatic test_single_player();
      kick2(2'b10, 3'b100);
      collect2(-1);
      total++;
      if (xs[0] !== 8'd118 || ys[0] !== 7'd4 || cs[0] !== 3'd4) begin
         bad++;
         $display("FAIL single_first: got x=%0d y=%0d c=%0d expected x=118 y=4 c=4", xs[0], ys[0], cs[0]);
      end
      total++;
      if (xs[153] !== 8'd123 || ys[153] !== 7'd7) begin
         bad++;
         $display("FAIL single_right_first: got x=%0d y=%0d expected x=123 y=7", xs[153], ys[153]);
      end
      total++;
      if (npix !== 297) begin
         bad++;
         $display("FAIL single_count: got %0d expected 297", npix);
      end
      total++;
      if (bus2.done !== 1'b1) begin
         bad++;
         $display("FAIL single_done: got %b expected 1", bus2.done);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_zero_mask();
      int hits;
      kick2(2'b00, 3'b001);
      total++;
      if (bus2.done !== 1'b1 || bus2.plot !== 1'b0 || bus2.busy !== 1'b0) begin
         bad++;
         $display("FAIL zero_done: got done=%b plot=%b busy=%b expected 1 0 0",
                  bus2.done, bus2.plot, bus2.busy);
      end
      hits = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (bus2.plot !== 1'b0 || bus2.busy !== 1'b0 || bus2.done !== 1'b0) hits++;
      end
      total++;
      if (hits !== 0) begin
         bad++;
         $display("FAIL zero_quiet: got %0d active cycles expected 0", hits);
      end
   endtask

   task automatic test_start_ignored();
      int col_bad;
      kick2(2'b11, 3'b010);
      collect2(50);
      total++;
      if (npix !== 594) begin
         bad++;
         $display("FAIL ignore_count: got %0d expected 594", npix);
      end
      col_bad = 0;
      for (int i = 0; i < 594; i++) if (cs[i] !== 3'b010) col_bad++;
      total++;
      if (col_bad !== 0) begin
         bad++;
         $display("FAIL ignore_colour: got %0d wrong pixels expected 0", col_bad);
      end
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (bus2.plot !== 1'b0 || bus2.colour !== 3'b010) begin
         bad++;
         $display("FAIL ignore_no_restart: got plot=%b colour=%0d expected 0 2", bus2.plot, bus2.colour);
      end
   endtask

   task automatic test_reset_mid_run();
      int hits;
      kick2(2'b11, 3'b110);
      repeat (100) @(posedge clk);
      #1;
      total++;
      if (bus2.plot !== 1'b1) begin
         bad++;
         $display("FAIL midrst_running: got plot=%b expected 1", bus2.plot);
      end
      reset = 1'b1;
      #1;
      total++;
      if ({bus2.x, bus2.y, bus2.colour, bus2.plot, bus2.busy, bus2.done} !== 21'd0) begin
         bad++;
         $display("FAIL midrst_clear: got %h expected 0",
                  {bus2.x, bus2.y, bus2.colour, bus2.plot, bus2.busy, bus2.done});
      end
      @(posedge clk); #1;
      reset = 1'b0;
      hits = 0;
      repeat (1000) begin
         @(posedge clk); #1;
         if (bus2.plot !== 1'b0 || bus2.busy !== 1'b0 || bus2.done !== 1'b0) hits++;
      end
      total++;
      if (hits !== 0) begin
         bad++;
         $display("FAIL midrst_quiet: got %0d active cycles expected 0", hits);
      end
   endtask

   task automatic test_back_to_back();
      bus2.player_mask = 2'b01;
      bus2.colour_in   = 3'b011;
      bus2.start       = 1'b1;
      @(posedge clk); #1;
      collect2(-1);
      total++;
      if (npix !== 297 || bus2.done !== 1'b1) begin
         bad++;
         $display("FAIL b2b_first_run: got count=%0d done=%b expected 297 1", npix, bus2.done);
      end
      @(posedge clk); #1;
      total++;
      if (bus2.plot !== 1'b0 || bus2.done !== 1'b0) begin
         bad++;
         $display("FAIL b2b_idle_gap: got plot=%b done=%b expected 0 0", bus2.plot, bus2.done);
      end
      @(posedge clk); #1;
      total++;
      if (bus2.plot !== 1'b1 || bus2.x !== 8'd38 || bus2.y !== 7'd4) begin
         bad++;
         $display("FAIL b2b_restart: got plot=%b x=%0d y=%0d expected 1 38 4", bus2.plot, bus2.x, bus2.y);
      end
      bus2.start = 1'b0;
      collect2(-1);
      total++;
      if (npix !== 297 || bus2.done !== 1'b1) begin
         bad++;
         $display("FAIL b2b_second_run: got count=%0d done=%b expected 297 1", npix, bus2.done);
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_small_boxes();
      int         n;
      logic [7:0] fx;
      logic [6:0] fy;
      logic [7:0] lx;
      logic [6:0] ly;
      bus3.player_mask = 3'b100;
      bus3.colour_in   = 3'b011;
      bus3.start       = 1'b1;
      @(posedge clk); #1;
      bus3.start = 1'b0;
      fx = bus3.x;
      fy = bus3.y;
      lx = '0;
      ly = '0;
      n  = 0;
      while (bus3.plot === 1'b1 && n < 200) begin
         lx = bus3.x;
         ly = bus3.y;
         @(posedge clk); #1;
         n++;
      end
      total++;
      if (fx !== 8'd198 || fy !== 7'd4) begin
         bad++;
         $display("FAIL small_first: got x=%0d y=%0d expected x=198 y=4", fx, fy);
      end
      total++;
      if (n !== 33) begin
         bad++;
         $display("FAIL small_count: got %0d expected 33", n);
      end
      total++;
      if (lx !== 8'd203 || ly !== 7'd100) begin
         bad++;
         $display("FAIL small_last: got x=%0d y=%0d expected x=203 y=100", lx, ly);
      end
      total++;
      if (bus3.done !== 1'b1) begin
         bad++;
         $display("FAIL small_done: got %b expected 1", bus3.done);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      bus2.start       = 1'b0;
      bus2.player_mask = '0;
      bus2.colour_in   = '0;
      bus3.start       = 1'b0;
      bus3.player_mask = '0;
      bus3.colour_in   = '0;
      test_reset();
      test_full_run();
      test_single_player();
      test_zero_mask();
      test_start_ignored();
      test_reset_mid_run();
      test_back_to_back();
      test_small_boxes();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lane_box_painter.md
# lane_box_painter

Parametrised pixel-fill sequencer that repaints the lane step boxes of every player column on the 160x120 VGA frame. It takes a start request, a player mask and a fill colour, and walks every enabled player's left-side and right-side box list. For each box it fills a BOX_W x BOX_H rectangle, one pixel per clock. It sits between the game control FSM and the VGA adapter write port. It generalises the single-pixel, two-player, white-only box reset to N players, arbitrary box size, selectable colour and a start/busy/done handshake.

## Interface
- PLAYERS, 2, number of player columns (1-4).
- X_BASE, 38, x of player 0 left-side boxes.
- X_STRIDE, 80, x offset between consecutive players.
- RIGHT_DX, 5, x offset of right-side boxes from left-side boxes.
- BOX_W, 3, box width in pixels (1-8).
- BOX_H, 3, box height in pixels (1-8).
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a repaint.
- player_mask  input  PLAYERS  bit p enables player p; sampled with start.
- colour_in  input  3  fill colour; sampled with start.
- x  output  8  pixel x coordinate.
- y  output  7  pixel y coordinate.
- colour  output  3  pixel colour.
- plot  output  1  VGA write enable, high for exactly one cycle per pixel.
- busy  output  1  high from the cycle after start is accepted until the last pixel.
- done  output  1  one-cycle pulse after the last pixel.

## Operation
- Fixed box tables:
  - Left-side y list, 17 entries, in order: 4,13,19,22,25,31,37,49,58,61,67,76,82,85,88,94,97.
  - Right-side y list, 16 entries, in order: 7,10,16,28,34,40,43,46,52,55,64,70,73,79,91,100.
- States: IDLE, PAINT, DONE.
- IDLE:
  - If start=1, latch player_mask and colour_in, then select the lowest enabled player.
  - If the mask is nonzero, go to PAINT; if the mask is zero, go directly to DONE.
  - start is ignored in PAINT and DONE.
- PAINT scan order, outermost to innermost:
  - Enabled players, ascending.
  - Side: left list, then right list.
  - Table index, ascending.
  - Row 0..BOX_H-1.
  - Column 0..BOX_W-1.
- Coordinates emitted in PAINT:
  - x = X_BASE + p*X_STRIDE + (right ? RIGHT_DX : 0) + col, truncated to 8 bits.
  - y = table[idx] + row, truncated to 7 bits.
  - No clipping is applied.
- Disabled players are skipped with no idle cycles between enabled players.
- After the final pixel, go to DONE for one cycle, then return to IDLE.
- colour always drives the latched colour; it changes only when a start is accepted.

## Timing
- Reset, asynchronous: state=IDLE, x=0, y=0, colour=0, plot=0, busy=0, done=0. Counters and latched registers are cleared.
- Reset asserted mid-PAINT: plot drops in the same cycle and no further pixels are emitted. After release the block waits in IDLE for a new start.
- Outputs are registered. When start is sampled high at edge k in IDLE with a nonzero mask:
  - The first pixel (x, y, colour, plot=1) is valid from edge k+1.
  - One pixel is emitted per cycle, with no bubbles.
  - Pixel count = popcount(mask) * 33 * BOX_W * BOX_H.
  - busy=1 exactly while plot=1.
  - done=1 for one cycle directly after the last pixel.
- Zero mask: done=1 at edge k+1, busy and plot stay 0.
- Outside PAINT: x and y hold their last values, plot=0.
- start held high continuously: a new run begins in the IDLE cycle after done.

## Test plan
- Reset, then start with mask=2'b11 and colour_in=3'b111 (defaults):
  - First pixel is x=38, y=4.
  - Pixel 297 is x=45, y=102, the last pixel of player 0.
  - Pixel 298 is x=118, y=4.
  - Exactly 594 plot cycles, then done one cycle later.
- mask=2'b10 and colour_in=3'b100:
  - First pixel is x=118, y=4, colour=4.
  - The first right-side pixel (index 154) is x=123, y=7.
  - 297 pixels total.
- mask=0 -> done at k+1; plot never asserts, busy stays 0.
- Pulse start again at pixel 50 of a run -> ignored; the pixel count and colour are unchanged.
- Assert reset at pixel 100:
  - All outputs are 0 immediately.
  - After release with no start, plot stays 0 for 1000 cycles.
- PLAYERS=3, BOX_W=1, BOX_H=1, mask=3'b100:
  - First pixel is x=198, y=4.
  - 33 pixels total.
  - The last pixel is x=203, y=100.
